// File: rtl/pc_unit.sv
// Program-counter unit: next-fetch-address selection (increment, branch, return)
// and a circular return-address stack for call/return.
module pc_unit #(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc1,
  input  logic                         inc2,
  input  logic                         stall,
  input  logic                         ld_uncond,
  input  logic                         ld_cond,
  input  logic [ADDR_W-1:0]            uncond_target,
  input  logic [ADDR_W-1:0]            cond_target,
  input  logic                         call,
  input  logic [ADDR_W-1:0]            link_addr,
  input  logic                         ret,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

  logic              do_pop;
  logic              do_push;
  logic              stk_empty;
  logic              stk_full;
  logic [PTR_W-1:0]  top_ptr;
  logic [ADDR_W-1:0] ret_target;

  // ld_cond squashes both call and ret; ret beats a same-cycle call.
  always_comb begin
    do_pop     = ret & ~ld_cond;
    do_push    = call & ld_uncond & ~ld_cond & ~ret;
    stk_empty  = (count_q == '0);
    stk_full   = (count_q == FULL_CNT);
    top_ptr    = ptr_q - PTR_W'(1);
    ret_target = stk_empty ? RESET_VEC : ras_q[top_ptr];
  end

  always_comb begin
    pc_d = pc_q;
    if (ld_cond)        pc_d = cond_target;
    else if (ret)       pc_d = ret_target;
    else if (ld_uncond) pc_d = uncond_target;
    else if (stall)     pc_d = pc_q;
    else if (inc2)      pc_d = pc_q + ADDR_W'(2);
    else if (inc1)      pc_d = pc_q + ADDR_W'(1);
  end

  // Stack bookkeeping; a set of the error flag wins over err_clr.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q & ~err_clr;
    for (int i = 0; i < RAS_DEPTH; i++) ras_d[i] = ras_q[i];
    if (do_pop) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d   = top_ptr;
        count_d = count_q - CNT_W'(1);
      end
    end else if (do_push) begin
      ras_d[ptr_q] = link_addr;
      ptr_d        = ptr_q + PTR_W'(1);
      if (stk_full) err_d   = 1'b1;
      else          count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_count = count_q;
  assign ras_empty = stk_empty;
  assign ras_full  = stk_full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step drives one cycle of inputs, pushes the
// expected post-edge state to a queue and pops/compares it after the edge.
module tb_pc_unit;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int W      = ADDR_W + CNT_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inc1, inc2, stall, ld_uncond, ld_cond, call, ret, err_clr;
  logic [ADDR_W-1:0] uncond_target, cond_target, link_addr;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty, ras_full, ras_err;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [ADDR_W-1:0] m_pc;

  pc_unit #(.ADDR_W(ADDR_W), .RESET_VEC(8'h00), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .inc1(inc1), .inc2(inc2), .stall(stall),
    .ld_uncond(ld_uncond), .ld_cond(ld_cond), .uncond_target(uncond_target),
    .cond_target(cond_target), .call(call), .link_addr(link_addr), .ret(ret),
    .err_clr(err_clr), .pc(pc), .pc_next(pc_next), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack_exp(input logic [ADDR_W-1:0] p,
                                            input logic [CNT_W-1:0] c,
                                            input logic e);
    return {p, c, (c == 0), (c == CNT_W'(DEPTH)), e};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    inc1 = 0; inc2 = 0; stall = 0; ld_uncond = 0; ld_cond = 0;
    call = 0; ret = 0; err_clr = 0;
    uncond_target = '0; cond_target = '0; link_addr = '0;
  endtask

  // Inputs are already driven (just after a negedge); ends at the next negedge.
  task automatic step(input string tag, input logic [ADDR_W-1:0] e_pc,
                      input logic [CNT_W-1:0] e_cnt, input logic e_err);
    logic [W-1:0] e;
    string        t;
    #1;
    check({tag, "/pc_next"}, {6'b0, pc_next}, {6'b0, e_pc});
    exp_q.push_back(pack_exp(e_pc, e_cnt, e_err));
    tag_q.push_back(tag);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {pc, ras_count, ras_empty, ras_full, ras_err}, e);
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    clr_in();
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {pc, ras_count, ras_empty, ras_full, ras_err}, pack_exp(8'h00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // increments and wraparound
    ld_uncond = 1; uncond_target = 8'hFE;  step("load_fe", 8'hFE, 0, 0);
    inc1 = 1;                              step("inc1_wrap", 8'hFF, 0, 0);
    inc2 = 1;                              step("inc2_wrap", 8'h01, 0, 0);
    inc2 = 1; stall = 1;                   step("stall_hold", 8'h01, 0, 0);
    inc1 = 1; inc2 = 1;                    step("inc2_wins", 8'h03, 0, 0);

    m_pc = 8'h03;
    for (int i = 0; i < 24; i++) begin
      inc1  = 1'($urandom_range(0, 1));
      inc2  = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      if (!stall) m_pc = inc2 ? m_pc + 8'd2 : (inc1 ? m_pc + 8'd1 : m_pc);
      step("rand_inc", m_pc, 0, 0);
    end

    // call then back-to-back return
    call = 1; ld_uncond = 1; uncond_target = 8'h20; link_addr = 8'h11;
    step("call", 8'h20, 1, 0);
    ret = 1;                               step("ret_b2b", 8'h11, 0, 0);

    // ld_cond priority squashes ret and call
    call = 1; ld_uncond = 1; uncond_target = 8'h30; link_addr = 8'h33;
    step("call2", 8'h30, 1, 0);
    ld_cond = 1; cond_target = 8'h40; ld_uncond = 1; uncond_target = 8'h80;
    ret = 1; stall = 1; call = 1; link_addr = 8'h77;
    step("prio_cond", 8'h40, 1, 0);
    ret = 1;                               step("ret_after_squash", 8'h33, 0, 0);
    call = 1; inc1 = 1; link_addr = 8'h55; step("call_no_ld", 8'h34, 0, 0);

    // call+ret together on empty stack: ret wins and underflows
    call = 1; ret = 1; ld_uncond = 1; uncond_target = 8'h90; link_addr = 8'h66;
    step("call_ret_uflow", 8'h00, 0, 1);
    err_clr = 1;                           step("err_clr", 8'h00, 0, 0);

    // overflow: five calls into a four-deep stack
    for (int i = 1; i <= 5; i++) begin
      call = 1; ld_uncond = 1; uncond_target = 8'(8'h50 + i); link_addr = 8'(i);
      step("ovf_call", 8'(8'h50 + i), (i > 4) ? 3'd4 : 3'(i), (i == 5));
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      step("ovf_ret", 8'(5 - i), 3'(3 - i), 1);
    end
    ret = 1;                               step("uflow_ret", 8'h00, 0, 1);
    ret = 1; err_clr = 1;                  step("set_beats_clr", 8'h00, 0, 1);
    err_clr = 1;                           step("err_clr2", 8'h00, 0, 0);
    ret = 1;                               step("uflow_again", 8'h00, 0, 1);
    call = 1; ld_uncond = 1; uncond_target = 8'h60; link_addr = 8'h99;
    step("call_after_uflow", 8'h60, 1, 1);

    // asynchronous reset mid-run
    rst_n = 1'b0; #1;
    check("async_reset", {pc, ras_count, ras_empty, ras_full, ras_err}, pack_exp(8'h00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    ret = 1;                               step("ret_after_reset", 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined RISC core; successor to the 8-bit fetch PC. Selects the next fetch address from single/double increment, stage-2 unconditional branch, stage-3 conditional branch and subroutine return. Holds an internal circular return-address stack (RAS) for call/return. Drives the fetch address selector and the stage-1 PC buffer.

## Interface
- ADDR_W, 8, width of every address port and of the PC register.
- RESET_VEC, 0, PC value after reset and PC target on an empty-stack return.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, ≥2).

- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- inc1  in  1  increment PC by 1 (single-word instruction).
- inc2  in  1  increment PC by 2 (two-word instruction); wins over inc1.
- stall  in  1  bus-busy; blocks inc1/inc2 only, never blocks loads or returns.
- ld_uncond  in  1  load uncond_target (stage 2).
- ld_cond  in  1  load cond_target (stage 3, condition flag true).
- uncond_target  in  ADDR_W  stage-2 branch address.
- cond_target  in  ADDR_W  stage-3 branch address.
- call  in  1  qualifies ld_uncond as a call; push link_addr.
- link_addr  in  ADDR_W  return address supplied by stage 2 with a call.
- ret  in  1  return: load PC from RAS top and pop.
- err_clr  in  1  synchronous clear of ras_err.
- pc  out  ADDR_W  registered PC, to address selector.
- pc_next  out  ADDR_W  combinational next PC, to PC buffer 1.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_err  out  1  sticky overflow/underflow flag.

## Operation
- Next-PC priority, highest first: ld_cond → cond_target; ret → RAS top; ld_uncond → uncond_target; stall → pc; inc2 → pc+2; inc1 → pc+1; else pc.
- All adds modulo 2^ADDR_W; pc = max value with inc1 → 0, with inc2 → 1.
- ld_cond squashes same-cycle call and ret: RAS and ras_count unchanged.
- Call = call & ld_uncond & ~ld_cond & ~ret: write link_addr at top pointer, pointer+1 mod RAS_DEPTH, count+1.
- call without ld_uncond: ignored.
- call and ret together (no ld_cond): ret wins, no push.
- Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_err set.
- Pop (ret & ~ld_cond) when count > 0: pc_next = entry at pointer−1, pointer−1, count−1.
- Pop when empty: pc_next = RESET_VEC, pointer/count unchanged, ras_err set.
- ras_err: set on overflow/underflow; cleared by err_clr (set wins if both same cycle); cleared by reset.

## Timing
- Reset (async assert, sync use after deassert): pc = RESET_VEC, pointer = 0, ras_count = 0, ras_empty = 1, ras_full = 0, ras_err = 0; entries cleared to 0. pc_next = RESET_VEC+inc while in reset irrelevant; reset mid-call/ret discards the operation.
- pc_next combinational from current-cycle inputs and state; pc <= pc_next on every posedge (1-cycle latency, no bubble on redirect).
- RAS write/pop and ras_count update on the same posedge as pc; flags registered-derived, valid the cycle after.
- Return directly after call (back-to-back cycles) returns the just-pushed link_addr.

## Test plan
- Reset: rst_n=0 mid-run → pc=0x00, ras_count=0, ras_empty=1, ras_err=0 immediately (async).
- Increments: pc=0xFE, inc1 → 0xFF, inc2 → 0x01; stall=1 with inc2 → pc holds.
- Priority: ld_cond=1 (0x40), ld_uncond=1 (0x80), ret=1, stall=1 → pc=0x40, ras_count unchanged.
- Call/return: call+ld_uncond target 0x20 link 0x11 → pc=0x20, count=1; next cycle ret → pc=0x11, count=0, ras_empty=1.
- Overflow: 5 calls links 0x01..0x05 with RAS_DEPTH=4 → ras_full=1, ras_err=1; 4 rets → 0x05,0x04,0x03,0x02.
- Underflow: ret on empty → pc=RESET_VEC, ras_err=1; err_clr → ras_err=0 next cycle.
